// File: rtl/pong_pkg.sv
// Shared definitions for the pong match sequencer: state codes, winner codes and
// the default score width.
package pong_pkg;

    localparam int SCORE_W_DEF = 4;
    localparam int ST_W        = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SERVE = 3'd1;
    localparam logic [ST_W-1:0] ST_PLAY  = 3'd2;
    localparam logic [ST_W-1:0] ST_POINT = 3'd3;
    localparam logic [ST_W-1:0] ST_OVER  = 3'd4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_SERVE = ST_SERVE,
        S_PLAY  = ST_PLAY,
        S_POINT = ST_POINT,
        S_OVER  = ST_OVER
    } match_state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Game-event inputs and match-status outputs of the pong match sequencer.
// master = stimulus side (ball block, video timing, button), slave = sequencer.
interface pong_match_ctrl_if
    import pong_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
);
    logic               i_frame_tick;
    logic               i_start;
    logic               i_miss_p1;
    logic               i_miss_p2;
    logic               o_ball_enable;
    logic               o_ball_reset;
    logic [SCORE_W-1:0] o_score_p1;
    logic [SCORE_W-1:0] o_score_p2;
    logic [ST_W-1:0]    o_state;
    logic [1:0]         o_winner;

    modport master (
        output i_frame_tick, i_start, i_miss_p1, i_miss_p2,
        input  o_ball_enable, o_ball_reset, o_score_p1, o_score_p2, o_state, o_winner
    );

    modport slave (
        input  i_frame_tick, i_start, i_miss_p1, i_miss_p2,
        output o_ball_enable, o_ball_reset, o_score_p1, o_score_p2, o_state, o_winner
    );
endinterface

// File: rtl/pong_match_ctrl_serve_timer.sv
// serve_timer: counts enabled frame ticks; o_done flags the tick that brings the
// count to FRAMES. Only used when PONG_AUTO_SERVE_EN is defined.
module serve_timer #(
    parameter int FRAMES = 60
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);
    localparam int              CNT_W = $clog2(FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_done = i_en && (cnt_q == LAST);
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match FSM (IDLE/SERVE/PLAY/POINT/OVER), score keeping and
// registered ball gating. Define PONG_AUTO_SERVE_EN for frame-timed auto-serve.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pong_match_ctrl_if.slave bus
);
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    match_state_e       state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [1:0]         winner_q, winner_d;
    logic               ball_en_q;
    logic               ball_rst_q;
    logic               serve_go;

`ifdef PONG_AUTO_SERVE_EN
    // Counter is held clear outside SERVE, so every SERVE entry starts from zero.
    serve_timer #(
        .FRAMES (SERVE_FRAMES)
    ) u_serve_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (state_q != S_SERVE),
        .i_en    (bus.i_frame_tick && (state_q == S_SERVE)),
        .o_done  (serve_go)
    );
`else
    logic unused_cfg;

    assign serve_go   = bus.i_start;
    assign unused_cfg = bus.i_frame_tick ^ (SERVE_FRAMES > 0);
`endif

    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.i_start) begin
                    state_d  = S_SERVE;
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = WIN_NONE;
                end
            end
            S_SERVE: begin
                if (serve_go) state_d = S_PLAY;
            end
            S_PLAY: begin
                // A double miss is a dead ball: replay the serve, nobody scores.
                if (bus.i_miss_p1 && bus.i_miss_p2) begin
                    state_d = S_SERVE;
                end else if (bus.i_miss_p1) begin
                    score2_d = score2_q + SCORE_W'(1);
                    state_d  = S_POINT;
                end else if (bus.i_miss_p2) begin
                    score1_d = score1_q + SCORE_W'(1);
                    state_d  = S_POINT;
                end
            end
            S_POINT: begin
                if (score1_q == WIN_VAL) begin
                    state_d  = S_OVER;
                    winner_d = WIN_P1;
                end else if (score2_q == WIN_VAL) begin
                    state_d  = S_OVER;
                    winner_d = WIN_P2;
                end else begin
                    state_d = S_SERVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            score1_q   <= '0;
            score2_q   <= '0;
            winner_q   <= WIN_NONE;
            ball_en_q  <= 1'b0;
            ball_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            winner_q   <= winner_d;
            // Decoded from next-state so the outputs match the state being entered.
            ball_en_q  <= (state_d == S_PLAY);
            ball_rst_q <= (state_d == S_IDLE) || (state_d == S_SERVE);
        end
    end

    assign bus.o_state       = state_q;
    assign bus.o_score_p1    = score1_q;
    assign bus.o_score_p2    = score2_q;
    assign bus.o_winner      = winner_q;
    assign bus.o_ball_enable = ball_en_q;
    assign bus.o_ball_reset  = ball_rst_q;
endmodule
